ctr_plaintext_packer: RTL and testbench

Upstream input stage for the AES-256 CTR encryption core. Accepts plaintext as a stream of 128-bit words over a valid/ready handshake and packs up to eight of them into the 1024-bit plaintext bus. Captures the key and IV per message and emits one packed chunk with a word count. Messages longer than eight words are split into consecutive chunks, with the IV advanced by 8 per continuation.

---
 rtl/ctr_plaintext_packer_pkg.sv | 16 +
 rtl/ctr_iv_advance.sv | 14 +
 rtl/ctr_plaintext_packer.sv | 134 +++++++++++++
 tb/tb_ctr_plaintext_packer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ctr_plaintext_packer_pkg.sv
// Constants and state encoding shared by the plaintext packer and the CTR encryption core,
// so that chunk width and counter stepping always agree.
package ctr_plaintext_packer_pkg;

  localparam int WORD_W    = 128;
  localparam int NUM_WORDS = 8;
  localparam int CHUNK_W   = WORD_W * NUM_WORDS;
  localparam int CTR_STEP  = NUM_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_e;

endpackage

// File: rtl/ctr_iv_advance.sv
// Combinational counter advance: the IV for the next chunk of a message, modulo 2^W.
module ctr_iv_advance
  import ctr_plaintext_packer_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic [W-1:0] iv_i,
  output logic [W-1:0] iv_o
);

  // Overflow past 2^W is dropped on purpose: the counter wraps silently.
  assign iv_o = iv_i + W'(CTR_STEP);

endmodule

// File: rtl/ctr_plaintext_packer.sv
// Packs a valid/ready stream of plaintext words into MSB-first chunks of NUM_WORDS words,
// capturing key/IV per message and stepping the IV for continuation chunks.
module ctr_plaintext_packer #(
  parameter int WORD_W    = ctr_plaintext_packer_pkg::WORD_W,
  parameter int NUM_WORDS = ctr_plaintext_packer_pkg::NUM_WORDS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [WORD_W-1:0]           s_data,
  input  logic                        s_last,
  input  logic [255:0]                key_in,
  input  logic [WORD_W-1:0]           iv_in,
  output logic [WORD_W*NUM_WORDS-1:0] plaintext_out,
  output logic [255:0]                key_out,
  output logic [WORD_W-1:0]           iv_out,
  output logic [3:0]                  word_count,
  output logic                        cont,
  output logic                        block_valid,
  input  logic                        block_ready
);
  import ctr_plaintext_packer_pkg::*;

  localparam int FILL_W = 4;

  state_e              state_q, state_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [255:0]        key_q;
  logic [WORD_W-1:0]   iv_q, iv_step;
  logic [3:0]          count_q;
  logic                cont_q, pend_q, s_ready_q, valid_q;
  logic                beat, done_beat, release_chunk;
  logic [NUM_WORDS-1:0] word_we;

  assign beat          = s_valid && s_ready_q;
  assign done_beat     = beat && (s_last || (fill_q == FILL_W'(NUM_WORDS - 1)));
  assign release_chunk = (state_q == HOLD) && block_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      s_ready_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      s_ready_q <= (state_d != HOLD);
      valid_q   <= (state_d == HOLD);
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE, FILL: begin
        if (beat) begin
          fill_d  = fill_q + FILL_W'(1);
          state_d = done_beat ? HOLD : FILL;
        end
      end
      HOLD: begin
        if (block_ready) begin
          state_d = IDLE;
          fill_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        fill_d  = '0;
      end
    endcase
  end

  ctr_iv_advance #(.W(WORD_W)) u_iv_advance (
    .iv_i (iv_q),
    .iv_o (iv_step)
  );

  // Chunk header: fresh key/IV on a new message, stepped IV on a continuation.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      iv_q    <= '0;
      count_q <= '0;
      cont_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      if (beat && (state_q == IDLE)) begin
        if (pend_q) begin
          iv_q   <= iv_step;
          cont_q <= 1'b1;
        end else begin
          key_q  <= key_in;
          iv_q   <= iv_in;
          cont_q <= 1'b0;
        end
      end
      if (done_beat) begin
        count_q <= fill_q + FILL_W'(1);
        pend_q  <= !s_last;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
      logic [WORD_W-1:0] word_q;

      assign word_we[gi] = beat && (fill_q == FILL_W'(gi));

      always_ff @(posedge clk) begin
        if (rst || release_chunk) begin
          word_q <= '0;
        end else if (word_we[gi]) begin
          word_q <= s_data;
        end
      end

      // Word 0 lands in the most significant slot.
      assign plaintext_out[WORD_W*(NUM_WORDS-gi)-1 -: WORD_W] = word_q;
    end
  endgenerate

  assign s_ready     = s_ready_q;
  assign block_valid = valid_q;
  assign key_out     = key_q;
  assign iv_out      = iv_q;
  assign word_count  = count_q;
  assign cont        = cont_q;

endmodule

// File: tb/tb_ctr_plaintext_packer.sv
// Self-checking bench: directed scenarios plus randomized messages against a chunk-list model.
module tb_ctr_plaintext_packer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          block_ready = 1'b0;
  logic [127:0]  s_data = '0;
  logic [127:0]  iv_in = '0;
  logic [255:0]  key_in = '0;
  logic          s_ready;
  logic [1023:0] plaintext_out;
  logic [255:0]  key_out;
  logic [127:0]  iv_out;
  logic [3:0]    word_count;
  logic          cont;
  logic          block_valid;

  always #5 clk = ~clk;

  ctr_plaintext_packer #(.WORD_W(128), .NUM_WORDS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .key_in        (key_in),
    .iv_in         (iv_in),
    .plaintext_out (plaintext_out),
    .key_out       (key_out),
    .iv_out        (iv_out),
    .word_count    (word_count),
    .cont          (cont),
    .block_valid   (block_valid),
    .block_ready   (block_ready)
  );

  typedef struct {
    logic [1023:0] pt;
    logic [255:0]  key;
    logic [127:0]  iv;
    logic [3:0]    cnt;
    logic          cont;
  } chunk_t;

  chunk_t       exp_q[$];
  logic [127:0] words[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rand256();
    return {rand128(), rand128()};
  endfunction

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(rand128());
  endtask

  // Message -> list of emitted chunks: split into groups of 8, IV advances by 8 per group.
  task automatic model_msg(input logic [255:0] k, input logic [127:0] iv0, input bit with_last);
    int n = words.size();
    int nchunks = with_last ? (n + 7) / 8 : n / 8;
    for (int c = 0; c < nchunks; c++) begin
      chunk_t ch;
      int     cnt;
      cnt     = ((n - 8 * c) > 8) ? 8 : (n - 8 * c);
      ch.pt   = '0;
      ch.key  = k;
      ch.iv   = iv0 + 128'(8 * c);
      ch.cont = (c > 0);
      ch.cnt  = 4'(cnt);
      for (int j = 0; j < cnt; j++) ch.pt[1023 - 128 * j -: 128] = words[8 * c + j];
      exp_q.push_back(ch);
    end
  endtask

  task automatic service_hold(input int hold);
    chunk_t e;
    e = exp_q.pop_front();
    $display("[TB] chunk words=%0d cont=%0b iv=%h hold=%0d", e.cnt, e.cont, e.iv, hold);
    for (int h = 0; h <= hold; h++) begin
      check_val("block_valid", block_valid, 1);
      check_val("s_ready_hold", s_ready, 0);
      check_val("word_count", word_count, e.cnt);
      check_val("cont", cont, e.cont);
      check_val("iv_out", iv_out, e.iv);
      check_val("key_out", key_out, e.key);
      for (int j = 0; j < 8; j++)
        check_val($sformatf("pt_w%0d", j), plaintext_out[1023 - 128 * j -: 128],
                  e.pt[1023 - 128 * j -: 128]);
      if (h < hold) @(negedge clk);
    end
    block_ready = 1'b1;
    @(negedge clk);
    block_ready = 1'b0;
    check_val("s_ready_after", s_ready, 1);
    check_val("bv_after", block_valid, 0);
    check_val("pt_cleared", plaintext_out == '0, 1);
  endtask

  // gap < 0: random idle cycles between words; hold < 0: random backpressure in HOLD.
  task automatic send_msg(input logic [255:0] k, input logic [127:0] iv0, input int gap,
                          input int hold, input bit with_last);
    int n = words.size();
    model_msg(k, iv0, with_last);
    for (int w = 0; w < n; w++) begin
      bit done;
      int g;
      g = (w == 0) ? 0 : ((gap >= 0) ? gap : int'($urandom_range(0, 2)));
      repeat (g) begin
        s_valid     = 1'b0;
        block_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      s_valid     = 1'b1;
      s_data      = words[w];
      s_last      = with_last && (w == n - 1);
      key_in      = (w == 0) ? k : rand256();
      iv_in       = (w == 0) ? iv0 : rand128();
      block_ready = 1'($urandom_range(0, 1));
      check_val("s_ready", s_ready, 1);
      @(negedge clk);
      s_valid     = 1'b0;
      s_last      = 1'b0;
      block_ready = 1'b0;
      done = (with_last && (w == n - 1)) || (w % 8 == 7);
      check_val("block_valid_lat", block_valid, done);
      if (done) service_hold((hold < 0) ? int'($urandom_range(0, 3)) : hold);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_block_valid", block_valid, 0);
    check_val("rst_cont", cont, 0);
    check_val("rst_word_count", word_count, 0);
    check_val("rst_pt", plaintext_out == '0, 1);
    check_val("rst_key", key_out, 0);
    check_val("rst_iv", iv_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check_val("s_ready_post_rst", s_ready, 1);
    $display("[TB] reset applied");
  endtask

  initial begin
    do_reset();

    words.delete();
    words.push_back(128'h0123456789abcdef0123456789abcdef);
    send_msg(256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100,
             128'hffeeddccbbaa99887766554433221100, 0, 0, 1'b1);

    fill_words(2);
    send_msg(rand256(), rand128(), 3, 0, 1'b1);

    fill_words(16);
    send_msg(rand256(), rand128(), -1, -1, 1'b1);

    fill_words(9);
    send_msg(rand256(), 128'hfffffffffffffffffffffffffffffffc, -1, -1, 1'b1);

    fill_words(3);
    send_msg(rand256(), rand128(), -1, 20, 1'b1);

    // One full chunk leaves a continuation pending, then 5 more words before reset.
    fill_words(13);
    send_msg(rand256(), rand128(), -1, -1, 1'b0);
    do_reset();
    fill_words(1);
    send_msg(rand256(), rand128(), -1, -1, 1'b1);

    repeat (12) begin
      fill_words(int'($urandom_range(1, 20)));
      send_msg(rand256(), rand128(), -1, -1, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
